// File: rtl/imem_loader.sv
// Program loader and instruction-fetch front end for the MIPS core: streams words into
// a local instruction memory while holding the core in reset, then serves fetches by PC.
module imem_loader #(
  parameter int          DEPTH      = 32,
  parameter int          ADDR_W     = 5,
  parameter int          RESET_HOLD = 2,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic [31:0]       cur_pc,
  output logic [31:0]       instruction,
  output logic              core_reset,
  output logic              running,
  output logic [ADDR_W:0]   loaded_count,
  output logic              load_error
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       mem [DEPTH];
  logic              xfer;
  logic [ADDR_W-1:0] fetch_idx;

  // A fetch is served only for an aligned, in-range PC that hits a word loaded since reset.
  function automatic logic fetch_ok(input logic [31:0] pc, input logic [ADDR_W:0] cnt,
                                    input logic in_run);
    logic [ADDR_W-1:0] idx;
    idx = pc[ADDR_W+1:2];
    fetch_ok = in_run && (pc[1:0] == 2'b00) && (pc[31:ADDR_W+2] == '0)
               && ({1'b0, idx} < cnt);
  endfunction

  assign load_ready = (state == LOAD);
  assign xfer       = load_valid && load_ready;
  assign fetch_idx  = cur_pc[ADDR_W+1:2];

  always_comb begin
    instruction = NOP_WORD;
    if (fetch_ok(cur_pc, loaded_count, state == RUN))
      instruction = mem[fetch_idx];
  end

  // Memory is deliberately left out of reset; loaded_count masks stale contents.
  always_ff @(posedge clock) begin
    if (!reset && xfer)
      mem[loaded_count[ADDR_W-1:0]] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= LOAD;
      loaded_count <= '0;
      hold_cnt     <= '0;
      load_error   <= 1'b0;
      core_reset   <= 1'b1;
      running      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            loaded_count <= loaded_count + 1'b1;
            if (load_last || loaded_count == LAST_IDX) begin
              state    <= HOLD;
              hold_cnt <= '0;
              if (!load_last)
                load_error <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_END) begin
            state      <= RUN;
            hold_cnt   <= '0;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          core_reset <= 1'b0;
          running    <= 1'b1;
        end
        default: begin
          state      <= LOAD;
          core_reset <= 1'b1;
          running    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load/run, invalid fetches, gaps, overflow and resets.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic [31:0] cur_pc;
  logic [31:0] instruction;
  logic        core_reset;
  logic        running;
  logic [5:0]  loaded_count;
  logic        load_error;

  int checks = 0;
  int failures = 0;

  imem_loader dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_last    (load_last),
    .cur_pc       (cur_pc),
    .instruction  (instruction),
    .core_reset   (core_reset),
    .running      (running),
    .loaded_count (loaded_count),
    .load_error   (load_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    cur_pc = pc;
    #1;
    chk(tag, instruction, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic        bp_valid [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] bp_data  [5] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003,
                                32'hD000_0004, 32'hE000_0005};

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0; cur_pc = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_count", 32'(loaded_count), 32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    fetch("rst_fetch", 32'd0, 32'h0);

    // Basic load and run
    send(32'h2001_0005, 1'b0);
    send(32'h2002_000A, 1'b0);
    send(32'h0022_1820, 1'b1);
    chk("basic_count", 32'(loaded_count), 32'd3);
    chk("basic_ready_off", 32'(load_ready), 32'd0);
    chk("basic_hold0", 32'(core_reset), 32'd1);
    tick();
    chk("basic_hold1", 32'(core_reset), 32'd1);
    chk("basic_notrun", 32'(running), 32'd0);
    tick();
    chk("basic_release", 32'(core_reset), 32'd0);
    chk("basic_running", 32'(running), 32'd1);
    fetch("basic_pc0", 32'd0, 32'h2001_0005);
    fetch("basic_pc4", 32'd4, 32'h2002_000A);
    fetch("basic_pc8", 32'd8, 32'h0022_1820);
    fetch("unloaded_pc12", 32'd12, 32'h0);
    fetch("misaligned_pc82", 32'h82, 32'h0);
    fetch("range_pc100", 32'h100, 32'h0);
    send(32'hFFFF_FFFF, 1'b1);
    chk("run_ignore_load", 32'(loaded_count), 32'd3);

    // Backpressure and gaps
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_ready_%0d", i), 32'(load_ready), 32'd1);
      load_valid = bp_valid[i];
      load_data  = bp_data[i];
      load_last  = (i == 4);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("bp_ready_off", 32'(load_ready), 32'd0);
    chk("bp_count", 32'(loaded_count), 32'd3);
    tick(); tick();
    fetch("bp_idx0", 32'd0, 32'hA000_0001);
    fetch("bp_idx1", 32'd4, 32'hD000_0004);
    fetch("bp_idx2", 32'd8, 32'hE000_0005);
    fetch("bp_idx3", 32'd12, 32'h0);

    // Overflow: 32 words without load_last
    do_reset();
    for (int i = 0; i < 32; i++) send(32'h1000_0000 + 32'(i), 1'b0);
    chk("ovf_count", 32'(loaded_count), 32'd32);
    chk("ovf_error", 32'(load_error), 32'd1);
    chk("ovf_ready", 32'(load_ready), 32'd0);
    send(32'h0BAD_0BAD, 1'b0);
    chk("ovf_33rd_count", 32'(loaded_count), 32'd32);
    chk("ovf_notrun", 32'(running), 32'd0);
    tick();
    chk("ovf_running", 32'(running), 32'd1);
    fetch("ovf_mem31", 32'd124, 32'h1000_001F);
    fetch("ovf_mem0", 32'd0, 32'h1000_0000);
    chk("ovf_error_sticky", 32'(load_error), 32'd1);

    // Reset mid-run, then a single-word program
    do_reset();
    chk("rr_core_reset", 32'(core_reset), 32'd1);
    chk("rr_running", 32'(running), 32'd0);
    chk("rr_error_clr", 32'(load_error), 32'd0);
    fetch("rr_nop_after_reset", 32'd0, 32'h0);
    send(32'hDEAD_BEEF, 1'b1);
    tick(); tick();
    chk("rr_count", 32'(loaded_count), 32'd1);
    chk("rr_running2", 32'(running), 32'd1);
    fetch("rr_stale_masked", 32'd4, 32'h0);
    fetch("rr_pc0", 32'd0, 32'hDEAD_BEEF);

    // Reset coincident with a transfer
    do_reset();
    reset = 1'b1; load_valid = 1'b1; load_data = 32'h1234_5678; load_last = 1'b1;
    tick();
    reset = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    chk("rx_count", 32'(loaded_count), 32'd0);
    chk("rx_load_state", 32'(load_ready), 32'd1);
    chk("rx_core_reset", 32'(core_reset), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-load and instruction-fetch front end placed directly upstream of `Mips_core`. After reset it accepts a stream of 32-bit instruction words over a valid/ready port and writes them into an internal instruction memory, holding the core in reset. Once loading completes it releases the core and serves `instruction` reads addressed by the core's `cur_pc`. Replaces the bench-side preloaded instruction array with a deterministic, self-checking load sequence.

## Interface

- `DEPTH`, 32: instruction memory depth in 32-bit words; power of two.
- `ADDR_W`, 5: log2(`DEPTH`).
- `RESET_HOLD`, 2: cycles `core_reset` stays high after load completes; must be 1 or greater.
- `NOP_WORD`, 32'h0000_0000: word returned for any invalid or unloaded fetch.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_valid`  in  1  `load_data` and `load_last` are valid.
- `load_ready`  out  1  loader accepts a word this cycle.
- `load_data`  in  32  instruction word to store.
- `load_last`  in  1  marks the final word of the program.
- `cur_pc`  in  32  byte address from the core.
- `instruction`  out  32  fetched word (combinational read).
- `core_reset`  out  1  drives the core's `reset`.
- `running`  out  1  core released and executing.
- `loaded_count`  out  ADDR_W+1  number of words written since reset.
- `load_error`  out  1  sticky: memory filled without `load_last`.

## Operation

- States: LOAD, HOLD, RUN.
- Reset value of every output, applied on a clock edge with `reset`=1:
  - state=LOAD, `loaded_count`=0, hold counter=0, `load_error`=0.
  - `core_reset`=1, `running`=0.
  - `load_ready`=1, because it is decoded from state.
- Reset does not clear memory contents. Stale words are masked by `loaded_count`.
- LOAD:
  - `load_ready`=1.
  - A transfer occurs when `load_valid && load_ready`. It writes `mem[loaded_count]` = `load_data` and increments `loaded_count`.
  - With no transfer, all state holds. `load_valid` may stay high indefinitely.
  - Exit to HOLD on the transfer with `load_last`=1.
  - Also exit to HOLD on the transfer that makes `loaded_count`=DEPTH. If `load_last`=0 on that transfer, set `load_error`=1.
- HOLD:
  - `load_ready`=0 and `core_reset`=1.
  - The hold counter increments each cycle. At `RESET_HOLD`-1 go to RUN and clear the counter.
- RUN:
  - `core_reset`=0, `running`=1, `load_ready`=0.
  - Stays in RUN until `reset`.
  - Words offered on the load port are ignored.
- Fetch: idx = `cur_pc[ADDR_W+1:2]`. `instruction` = `mem[idx]` only when all of the following hold; otherwise `NOP_WORD`:
  - state is RUN;
  - `cur_pc[1:0]`==0;
  - `cur_pc[31:ADDR_W+2]`==0;
  - idx < `loaded_count`.
- Width rules:
  - `loaded_count` saturates at DEPTH and never wraps.
  - No write is possible beyond index DEPTH-1.

## Timing

- A load word is written at the edge where the transfer occurs. It is readable in RUN with no extra latency.
- Final transfer at edge N:
  - state=HOLD from N;
  - `core_reset` falls and `running` rises at edge N+`RESET_HOLD`.
  - The core therefore sees exactly `RESET_HOLD` full reset cycles after loading, in addition to the cycles spent in LOAD.
- Fetch is combinational from `cur_pc` and registered memory/state. There is no fetch pipeline stage.
- Reset has priority over every event, including a simultaneous transfer; that word is not written.
- Reset in HOLD or RUN:
  - returns to LOAD on that edge;
  - `core_reset` reasserts on that edge;
  - `instruction` returns to `NOP_WORD` immediately after.
- `load_error` clears only on reset.

## Test plan

- **Basic load and run.** Load 3 words 0x2001_0005, 0x2002_000A, 0x0022_1820 with `load_last` on word 3, then drive `cur_pc`=0,4,8.
  - `loaded_count`=3.
  - `core_reset` falls exactly 2 cycles after the last transfer.
  - `instruction` returns the three words in order.
- **Unloaded and invalid fetches.** After the same load, drive `cur_pc`=12, 0x0000_0082, and 0x0000_0100 → `instruction`=0x0000_0000 for each.
- **Backpressure and gaps.** Toggle `load_valid` 1,0,0,1,1 with distinct words, `load_last` on the final one.
  - Only 3 words are written, at indices 0,1,2.
  - `load_ready` stays 1 until the last transfer, then reads 0.
- **Overflow.** Stream 32 words without `load_last`.
  - `loaded_count`=32 and `load_error`=1.
  - `load_ready`=0 after word 32; a 33rd offered word is ignored.
  - `mem[31]` holds word 32; `running`=1 two cycles later.
- **Reset mid-run.** In RUN, assert `reset` for 1 cycle, then load 1 word 0xDEAD_BEEF with `load_last`.
  - `loaded_count`=1.
  - `cur_pc`=4 returns NOP even though old data remains.
  - `cur_pc`=0 returns 0xDEAD_BEEF.
- **Reset during transfer.** Assert `reset` on the same edge as a valid transfer → `loaded_count`=0 and state=LOAD.
